// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size encodings, FSM states,
// byte-enable generation and load lane extraction/extension.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The reserved size encoding is reported as misaligned so it never writes.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr[0];
      SZ_WORD: is_misaligned = |addr;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: be_gen = 4'b0001 << addr;
      SZ_HALF: be_gen = addr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      SZ_BYTE: store_lanes = {4{wd[7:0]}};
      SZ_HALF: store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] addr, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: load_ext = word;
      default: load_ext = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be.sv
// Word-organised data RAM with per-byte write enables and asynchronous read.
module data_memory_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: branch resolution, sized loads/stores with optional
// wait states and upstream stall, and the MEM/WB latch with flush support.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic [WB_W-1:0]   WBControl,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic              Branch,
  input  logic              Zero,
  output logic              PCSrc,
  output logic              stall,
  output logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic [WB_W-1:0]   WBControl_out,
  output logic              valid_out,
  output logic              misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic              mem_op;
  logic              is_load;
  logic              misaligned_c;
  logic              stall_c;
  logic              we;
  logic [1:0]        lane;
  logic [AW-1:0]     word_idx;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] load_data;

  logic [DATA_W-1:0] read_data_p1;
  logic [DATA_W-1:0] alu_result_p1;
  logic [REG_W-1:0]  write_reg_p1;
  logic [WB_W-1:0]   wb_ctl_p1;
  logic              misalign_p1;
  logic              vld_p1;

  assign lane         = ALUResult[1:0];
  assign word_idx     = ALUResult[AW+1:2];
  assign mem_op       = valid_in & (MemRead | MemWrite);
  assign is_load      = MemRead & ~MemWrite;
  assign misaligned_c = is_misaligned(MemSize, lane);
  assign be           = be_gen(MemSize, lane);
  assign wdata_lanes  = store_lanes(WriteData, MemSize);

  assign PCSrc = Branch & Zero & valid_in & ~flush;

  // A flushed slot never holds upstream, even mid-access.
  always_comb begin
    stall_c = 1'b0;
    if (!flush) begin
      if (state == IDLE) stall_c = mem_op && (WAIT_CYCLES != 0);
      else               stall_c = (cnt != 3'd0);
    end
  end

  assign stall = stall_c;

  // Only the completion edge of a live, aligned store reaches the RAM.
  assign we = mem_op & MemWrite & ~misaligned_c & ~stall_c & ~flush & ~rst;

  data_memory_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (word_idx),
    .wdata (wdata_lanes),
    .rdata (rdata)
  );

  assign load_data = (mem_op && is_load && !misaligned_c)
                     ? load_ext(rdata, MemSize, lane, MemUnsigned) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && (WAIT_CYCLES != 0)) begin
            state <= BUSY;
            cnt   <= WAIT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 3'd0) cnt   <= cnt - 3'd1;
          else             state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // ---- MEM/WB boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      wb_ctl_p1     <= '0;
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      write_reg_p1  <= '0;
      misalign_p1   <= 1'b0;
    end else if (stall_c || flush) begin
      vld_p1    <= 1'b0;
      wb_ctl_p1 <= '0;
    end else begin
      vld_p1        <= valid_in;
      wb_ctl_p1     <= valid_in ? WBControl : '0;
      read_data_p1  <= load_data;
      alu_result_p1 <= ALUResult;
      write_reg_p1  <= WriteReg;
      misalign_p1   <= mem_op & misaligned_c;
    end
  end

  assign ReadData      = read_data_p1;
  assign ALUResult_out = alu_result_p1;
  assign WriteReg_out  = write_reg_p1;
  assign WBControl_out = wb_ctl_p1;
  assign valid_out     = vld_p1;
  assign misalign      = misalign_p1;

endmodule
